multdiv_unit: RTL and testbench
===============================

Name: multdiv_unit

Overview:
- Parametrised iterative signed multiply/divide unit for the execute stage of the 5-stage pipeline; it fills the empty MULTDIV slot beside the ALU.
- The DX stage issues a one-cycle start pulse with operands and stalls FD/DX while busy.
- The result and exception bit join the ALU result and overflow onto the XM latch input when data_resultRDY pulses.
- This is the first execute unit in the design with multi-cycle latency, a handshake and abort/restart behaviour.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- CNT_W, 6, iteration-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  master clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- data_operandA  input  WIDTH  multiplicand / dividend, signed; sampled on start.
- data_operandB  input  WIDTH  multiplier / divisor, signed; sampled on start.
- ctrl_MULT  input  1  one-cycle start pulse for multiply.
- ctrl_DIV  input  1  one-cycle start pulse for divide.
- data_result  output  WIDTH  signed result.
- data_exception  output  1  overflow / divide-by-zero flag; valid with data_result.
- data_resultRDY  output  1  one-cycle pulse: result and exception are valid.
- busy  output  1  operation in flight; the pipeline stalls on it.

Behaviour:
- Reset: reset==0 at a rising edge puts the FSM in IDLE and clears counter, operand registers, data_result, data_exception, data_resultRDY and busy to 0. Reset mid-operation aborts with no RDY pulse.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on a start.
  - RUN -> DONE after WIDTH iterations.
  - DONE -> IDLE, or DONE -> RUN if a start is present.
- Start: ctrl_MULT|ctrl_DIV sampled at edge k.
  - Operands and mode are latched.
  - Counter is cleared.
  - busy=1 from edge k.
  - If both are asserted, MULT wins; DIV is ignored.
- Fixed latency: data_resultRDY=1 for exactly the cycle after edge k+WIDTH+1, so it is observable in that cycle; busy=0 in that cycle.
  - This holds for every case, including divide-by-zero and early-detectable cases.
  - No data-dependent early exit.
- Restart: a start while busy (RUN) aborts the current operation. The new operands are latched, the counter restarts, and the aborted operation never pulses RDY.
- Start during DONE cycle: RDY still pulses for the old result and the new operation begins (back-to-back issue).
- Output hold: data_result and data_exception are registered, update only on the edge entering DONE, and are held until the next DONE or reset.
- Multiply: radix-2 signed (Booth or sign-corrected shift-add), one bit per cycle, 2*WIDTH-bit internal product.
  - data_result = low WIDTH bits.
  - data_exception=1 iff the full product is not representable in signed WIDTH bits, i.e. the upper WIDTH+1 bits are not all equal.
- Divide: restoring or non-restoring on magnitudes, one quotient bit per cycle; sign fixed in the final step. The quotient truncates toward zero; the remainder is discarded.
  - Divisor==0: data_result=0, data_exception=1.
  - Dividend = -2^(WIDTH-1) and divisor = -1: data_result = -2^(WIDTH-1), data_exception=1.
  - Otherwise data_exception=0.
- Inputs must not be assumed stable after the start cycle.
- No combinational path from inputs to outputs.

Test Plan (WIDTH=32):
- Reset held 2 cycles then released, no start -> all outputs 0 indefinitely. MULT pulse with A=6, B=7 -> RDY pulse exactly 33 cycles after the start edge; result=42; exception=0; busy high for 33 cycles.
- MULT -3*5 -> result 0xFFFFFFF1 (-15), exception=0. MULT 0x00010000*0x00010000 -> result 0x00000000, exception=1. MULT 0x80000000*1 -> 0x80000000, exception=0.
- DIV 100/7 -> 14. DIV -100/7 -> -14 (0xFFFFFFF2), exception=0. DIV 7/-100 -> 0.
- DIV 5/0 -> result 0, exception=1. DIV 0x80000000/0xFFFFFFFF -> result 0x80000000, exception=1. Both at full 33-cycle latency.
- Start MULT 3*4, then DIV 20/4 ten cycles later -> no RDY for the multiply; a single RDY 33 cycles after the DIV start with result 5. Start during the DONE cycle -> old RDY pulse plus new op completes 33 cycles later.
- reset=0 during RUN at cycle 15 -> no RDY, outputs 0. ctrl_MULT and ctrl_DIV together with 9, 3 -> result 27 (multiply).

Source files
------------

// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide unit for the execute stage.
// Radix-2 Booth multiply or restoring divide, one bit per cycle, fixed WIDTH+1 cycle latency.
module multdiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    // acc: Booth upper half / divide partial remainder, one guard bit wide
    logic [WIDTH:0]   acc_reg, acc_next;
    // q: multiplier shifting out / dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH-1:0] m_reg, m_next;
    logic             qm1_reg, qm1_next;
    logic             is_div_reg, is_div_next;
    logic             neg_reg, neg_next;
    logic             div0_reg, div0_next;
    logic             dovf_reg, dovf_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             exc_reg, exc_next;

    logic             start;
    logic             last_iter;
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH:0]   prod_hi;
    logic             mult_ovf;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    assign start     = ctrl_MULT | ctrl_DIV;
    assign last_iter = (cnt_reg == CNT_LAST);

    assign m_ext = {m_reg[WIDTH-1], m_reg};

    always_comb begin
        case ({q_reg[0], qm1_reg})
            2'b01:   booth_sum = acc_reg + m_ext;
            2'b10:   booth_sum = acc_reg - m_ext;
            default: booth_sum = acc_reg;
        endcase
    end

    assign div_shift = {acc_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, m_reg};

    // Product fits in signed WIDTH bits only when bits [2W-1:W-1] are all equal
    assign prod_hi  = {acc_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    assign mult_ovf = ~((&prod_hi) | ~(|prod_hi));

    // The most negative value maps onto its own unsigned magnitude
    assign abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        acc_next    = acc_reg;
        q_next      = q_reg;
        m_next      = m_reg;
        qm1_next    = qm1_reg;
        is_div_next = is_div_reg;
        neg_next    = neg_reg;
        div0_next   = div0_reg;
        dovf_next   = dovf_reg;
        result_next = result_reg;
        exc_next    = exc_reg;

        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN: begin
                if (start)          state_next = RUN;
                else if (last_iter) state_next = DONE;
            end
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase

        if (start) begin
            // A start in any state (including mid-run) discards the old operation
            cnt_next    = '0;
            acc_next    = '0;
            qm1_next    = 1'b0;
            is_div_next = ~ctrl_MULT;
            neg_next    = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div0_next   = (data_operandB == '0);
            dovf_next   = (data_operandA == MIN_NEG) && (&data_operandB);
            if (ctrl_MULT) begin
                q_next = data_operandA;
                m_next = data_operandB;
            end else begin
                q_next = abs_a;
                m_next = abs_b;
            end
        end else if (state_reg == RUN) begin
            if (!last_iter) begin
                cnt_next = cnt_reg + CNT_ONE;
                if (is_div_reg) begin
                    if (div_diff[WIDTH]) begin
                        acc_next = div_shift;
                        q_next   = {q_reg[WIDTH-2:0], 1'b0};
                    end else begin
                        acc_next = div_diff;
                        q_next   = {q_reg[WIDTH-2:0], 1'b1};
                    end
                end else begin
                    acc_next = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                    q_next   = {booth_sum[0], q_reg[WIDTH-1:1]};
                    qm1_next = q_reg[0];
                end
            end else if (is_div_reg) begin
                if (div0_reg) begin
                    result_next = '0;
                    exc_next    = 1'b1;
                end else begin
                    result_next = neg_reg ? -q_reg : q_reg;
                    exc_next    = dovf_reg;
                end
            end else begin
                result_next = q_reg;
                exc_next    = mult_ovf;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            q_reg      <= '0;
            m_reg      <= '0;
            qm1_reg    <= 1'b0;
            is_div_reg <= 1'b0;
            neg_reg    <= 1'b0;
            div0_reg   <= 1'b0;
            dovf_reg   <= 1'b0;
            result_reg <= '0;
            exc_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            acc_reg    <= acc_next;
            q_reg      <= q_next;
            m_reg      <= m_next;
            qm1_reg    <= qm1_next;
            is_div_reg <= is_div_next;
            neg_reg    <= neg_next;
            div0_reg   <= div0_next;
            dovf_reg   <= dovf_next;
            result_reg <= result_next;
            exc_reg    <= exc_next;
        end
    end

    assign data_result    = result_reg;
    assign data_exception = exc_reg;
    assign data_resultRDY = (state_reg == DONE);
    assign busy           = (state_reg == RUN);

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed corner cases, handshake scenarios
// and randomized operations against an arithmetic reference model.
module tb_multdiv_unit;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic          clock;
    logic          reset;
    logic [W-1:0]  data_operandA;
    logic [W-1:0]  data_operandB;
    logic          ctrl_MULT;
    logic          ctrl_DIV;
    logic [W-1:0]  data_result;
    logic          data_exception;
    logic          data_resultRDY;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    multdiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed 64-bit arithmetic
    task automatic ref_model(input bit is_mult, input logic [W-1:0] a, input logic [W-1:0] b,
                             output logic [W-1:0] res, output logic exc);
        longint sa, sb, p;
        sa = $signed(a);
        sb = $signed(b);
        if (is_mult) begin
            p   = sa * sb;
            res = p[W-1:0];
            exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        end else if (sb == 0) begin
            res = '0;
            exc = 1'b1;
        end else if (sa == -64'sd2147483648 && sb == -64'sd1) begin
            res = 32'h8000_0000;
            exc = 1'b1;
        end else begin
            p   = sa / sb;
            res = p[W-1:0];
            exc = 1'b0;
        end
    endtask

    // Drive a start pulse sampled on the next rising edge, then scramble the operands
    task automatic start_op(input bit m, input bit d, input logic [W-1:0] a, input logic [W-1:0] b);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Called right after the start edge; returns at the negedge where RDY was seen
    task automatic wait_result(input string tag, input logic [W-1:0] exp_res, input logic exp_exc,
                               input bit chk_pulse);
        int lat;
        int busy_n;
        lat    = -1;
        busy_n = 0;
        for (int j = 0; j <= LAT + 7; j++) begin
            @(negedge clock);
            if (data_resultRDY) begin
                lat = j;
                break;
            end
            if (busy) busy_n++;
        end
        $display("op %s res=%08h exc=%0b lat=%0d", tag, data_result, data_exception, lat);
        check({tag, " latency"}, 64'(lat), 64'(LAT));
        check({tag, " busy_cycles"}, 64'(busy_n), 64'(LAT));
        check({tag, " busy_at_rdy"}, {63'b0, busy}, 64'd0);
        check({tag, " result"}, {32'b0, data_result}, {32'b0, exp_res});
        check({tag, " exception"}, {63'b0, data_exception}, {63'b0, exp_exc});
        if (chk_pulse) begin
            @(negedge clock);
            check({tag, " rdy_one_cycle"}, {63'b0, data_resultRDY}, 64'd0);
            check({tag, " result_hold"}, {32'b0, data_result}, {32'b0, exp_res});
        end
    endtask

    task automatic run_op(input string tag, input bit m, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] er;
        logic         ee;
        ref_model(m, a, b, er, ee);
        start_op(m, ~m, a, b);
        wait_result(tag, er, ee, 1'b1);
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 3))
            0: v = $urandom;
            1: v = W'($urandom_range(0, 65535)) - 32'd32768;
            2: v = W'($urandom_range(0, 200)) - 32'd100;
            default: begin
                case ($urandom_range(0, 4))
                    0: v = 32'h0;
                    1: v = 32'hFFFF_FFFF;
                    2: v = 32'h8000_0000;
                    3: v = 32'h7FFF_FFFF;
                    default: v = 32'h1;
                endcase
            end
        endcase
        return v;
    endfunction

    initial begin
        logic [W-1:0] er;
        logic         ee;
        int           rdy_n;
        int           busy_n;

        reset         = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;

        rdy_n = 0; busy_n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (data_resultRDY) rdy_n++;
            if (busy) busy_n++;
        end
        check("idle rdy", 64'(rdy_n), 64'd0);
        check("idle busy", 64'(busy_n), 64'd0);
        check("idle result", {32'b0, data_result}, 64'd0);
        check("idle exception", {63'b0, data_exception}, 64'd0);

        run_op("mul 6*7", 1'b1, 32'd6, 32'd7);
        run_op("mul -3*5", 1'b1, 32'hFFFF_FFFD, 32'd5);
        run_op("mul 2^16*2^16", 1'b1, 32'h0001_0000, 32'h0001_0000);
        run_op("mul min*1", 1'b1, 32'h8000_0000, 32'd1);
        run_op("mul min*-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div 100/7", 1'b0, 32'd100, 32'd7);
        run_op("div -100/7", 1'b0, 32'hFFFF_FF9C, 32'd7);
        run_op("div 7/-100", 1'b0, 32'd7, 32'hFFFF_FF9C);
        run_op("div 5/0", 1'b0, 32'd5, 32'd0);
        run_op("div min/-1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div min/1", 1'b0, 32'h8000_0000, 32'd1);

        // Restart: DIV issued while the multiply is in flight
        start_op(1'b1, 1'b0, 32'd3, 32'd4);
        rdy_n = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            if (data_resultRDY) rdy_n++;
        end
        start_op(1'b0, 1'b1, 32'd20, 32'd4);
        check("restart no_rdy_before", 64'(rdy_n), 64'd0);
        wait_result("restart div 20/4", 32'd5, 1'b0, 1'b1);

        // Back-to-back: new start in the DONE cycle
        start_op(1'b1, 1'b0, 32'd11, 32'd13);
        wait_result("b2b first 11*13", 32'd143, 1'b0, 1'b0);
        start_op(1'b0, 1'b1, 32'hFFFF_FC18, 32'd10);
        wait_result("b2b second -1000/10", 32'hFFFF_FF9C, 1'b0, 1'b1);

        // Reset in the middle of a run
        start_op(1'b1, 1'b0, 32'd123, 32'd456);
        repeat (15) @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        rdy_n = 0; busy_n = 0;
        for (int i = 0; i < LAT + 8; i++) begin
            @(negedge clock);
            if (data_resultRDY) rdy_n++;
            if (busy) busy_n++;
        end
        $display("op reset-abort rdy_pulses=%0d busy_cycles=%0d", rdy_n, busy_n);
        check("abort rdy", 64'(rdy_n), 64'd0);
        check("abort busy", 64'(busy_n), 64'd0);
        check("abort result", {32'b0, data_result}, 64'd0);
        check("abort exception", {63'b0, data_exception}, 64'd0);

        // Both starts asserted: multiply wins
        start_op(1'b1, 1'b1, 32'd9, 32'd3);
        wait_result("both 9,3", 32'd27, 1'b0, 1'b1);

        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] a, b;
            bit           m;
            m = 1'($urandom_range(0, 1));
            a = pick_operand();
            b = pick_operand();
            ref_model(m, a, b, er, ee);
            start_op(m, ~m, a, b);
            wait_result($sformatf("rnd%0d %s %08h,%08h", i, m ? "mul" : "div", a, b), er, ee, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
